// File: rtl/lc3_cntrl_fsm.sv
// LC3 multi-cycle controller.
// Latches the fetched instruction and steps each opcode through the cntrl_e
// states. It resolves BR/JMP targets for the fetch unit, waits on memory acks,
// and aborts any memory wait that stalls too long.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   imem_ack, instr     instruction memory handshake and data (FETCH)
//   dmem_ack            data memory done (IND_ADDR_RD, READ_MEM, WRITE_MEM)
//   npc, base_val, nzp  pc+1, JMP base register, condition codes
//   state               current cntrl_e state (registered)
//   br_taken, taddr     pc redirect request and target (registered)
//   ir                  latched instruction register
//   illegal             sticky unsupported-opcode flag
//   timeout             one-cycle watchdog abort pulse
//   retired             count of completed instructions (wraps)
module lc3_cntrl_fsm #(
  parameter logic [3:0]  RESET_STATE = 4'd0,  // 4'd0 encodes CNTRL_FETCH
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  input  logic [15:0] instr,
  input  logic [15:0] npc,
  input  logic [15:0] base_val,
  input  logic [2:0]  nzp,
  output logic [3:0]  state,
  output logic        br_taken,
  output logic [15:0] taddr,
  output logic [15:0] ir,
  output logic        illegal,
  output logic        timeout,
  output logic [15:0] retired
);

  localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [3:0] {
    CNTRL_FETCH       = 4'd0,
    CNTRL_DECODE      = 4'd1,
    CNTRL_EXECUTE     = 4'd2,
    CNTRL_UPDATE_REGF = 4'd3,
    CNTRL_COMPUTE_PC  = 4'd4,
    CNTRL_COMPUTE_MEM = 4'd5,
    CNTRL_IND_ADDR_RD = 4'd6,
    CNTRL_READ_MEM    = 4'd7,
    CNTRL_WRITE_MEM   = 4'd8,
    CNTRL_UPDATE_PC   = 4'd9
  } cntrl_e;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  cntrl_e              state_q, state_d;
  logic                br_taken_d;
  logic [15:0]         taddr_d, ir_d, retired_d;
  logic                illegal_d, timeout_d;
  logic [WDOG_W-1:0]   wdog, wdog_d;
  logic                wait_st;
  logic [3:0]          opcode;

  assign opcode = ir[15:12];
  assign state  = state_q;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= cntrl_e'(RESET_STATE);
      br_taken <= 1'b0;
      taddr    <= 16'h0000;
      ir       <= 16'h0000;
      illegal  <= 1'b0;
      timeout  <= 1'b0;
      retired  <= 16'h0000;
      wdog     <= '0;
    end else begin
      state_q  <= state_d;
      br_taken <= br_taken_d;
      taddr    <= taddr_d;
      ir       <= ir_d;
      illegal  <= illegal_d;
      timeout  <= timeout_d;
      retired  <= retired_d;
      wdog     <= wdog_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    br_taken_d = br_taken;
    taddr_d    = taddr;
    ir_d       = ir;
    illegal_d  = illegal;
    timeout_d  = 1'b0;
    retired_d  = retired;
    wait_st    = 1'b0;

    case (state_q)
      CNTRL_FETCH: begin
        wait_st = 1'b1;
        if (imem_ack) begin
          ir_d    = instr;
          state_d = CNTRL_DECODE;
        end
      end
      CNTRL_DECODE: state_d = CNTRL_EXECUTE;
      CNTRL_EXECUTE: begin
        case (opcode)
          OP_ADD, OP_AND, OP_NOT, OP_LEA: state_d = CNTRL_UPDATE_REGF;
          OP_BR: begin
            state_d    = CNTRL_COMPUTE_PC;
            taddr_d    = npc + {{7{ir[8]}}, ir[8:0]};
            br_taken_d = |(ir[11:9] & nzp);
          end
          OP_JMP: begin
            state_d    = CNTRL_COMPUTE_PC;
            taddr_d    = base_val;
            br_taken_d = 1'b1;
          end
          OP_LD, OP_LDR, OP_LDI, OP_ST, OP_STR, OP_STI:
            state_d = CNTRL_COMPUTE_MEM;
          default: begin
            state_d    = CNTRL_UPDATE_PC;
            illegal_d  = 1'b1;
            br_taken_d = 1'b0;
          end
        endcase
      end
      CNTRL_COMPUTE_PC: state_d = CNTRL_UPDATE_PC;
      CNTRL_COMPUTE_MEM: begin
        // Only memory opcodes reach here, so the fall-through is ST/STR.
        case (opcode)
          OP_LDI, OP_STI: state_d = CNTRL_IND_ADDR_RD;
          OP_LD, OP_LDR:  state_d = CNTRL_READ_MEM;
          default:        state_d = CNTRL_WRITE_MEM;
        endcase
      end
      CNTRL_IND_ADDR_RD: begin
        wait_st = 1'b1;
        if (dmem_ack)
          state_d = (opcode == OP_LDI) ? CNTRL_READ_MEM : CNTRL_WRITE_MEM;
      end
      CNTRL_READ_MEM: begin
        wait_st = 1'b1;
        if (dmem_ack) state_d = CNTRL_UPDATE_REGF;
      end
      CNTRL_WRITE_MEM: begin
        wait_st = 1'b1;
        if (dmem_ack) state_d = CNTRL_UPDATE_PC;
      end
      CNTRL_UPDATE_REGF: state_d = CNTRL_UPDATE_PC;
      CNTRL_UPDATE_PC: begin
        retired_d  = retired + 16'd1;
        br_taken_d = 1'b0;
        state_d    = CNTRL_FETCH;
      end
      default: state_d = CNTRL_FETCH;
    endcase

    // Watchdog abort; an ack on the limit cycle changes state and so wins.
    if (wait_st && (state_d == state_q) &&
        (wdog == WDOG_W'(TIMEOUT_CYC - 1))) begin
      timeout_d  = 1'b1;
      state_d    = CNTRL_UPDATE_PC;
      br_taken_d = 1'b0;
    end

    wdog_d = (wait_st && (state_d == state_q)) ? wdog + WDOG_W'(1) : '0;
  end

endmodule

// File: tb/tb_lc3_cntrl_fsm.sv
// Self-checking bench for lc3_cntrl_fsm: directed instruction vectors, state
// trace checks, and a scoreboard of expected UPDATE_PC snapshots.
module tb_lc3_cntrl_fsm;

  logic        clk = 1'b0;
  logic        rst, imem_ack, dmem_ack;
  logic [15:0] instr, npc, base_val;
  logic [2:0]  nzp;
  logic [3:0]  state;
  logic        br_taken, illegal, timeout;
  logic [15:0] taddr, ir, retired;

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_EXECUTE = 4'd2;
  localparam logic [3:0] S_UPD_RF  = 4'd3;
  localparam logic [3:0] S_CMP_PC  = 4'd4;
  localparam logic [3:0] S_CMP_MEM = 4'd5;
  localparam logic [3:0] S_IND     = 4'd6;
  localparam logic [3:0] S_READ    = 4'd7;
  localparam logic [3:0] S_WRITE   = 4'd8;
  localparam logic [3:0] S_UPD_PC  = 4'd9;

  typedef struct packed {
    logic        br;
    logic [15:0] taddr;
    logic [15:0] retired;
    logic        illegal;
    logic        timeout;
    logic [15:0] ir;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  lc3_cntrl_fsm #(.RESET_STATE(4'd0), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .instr(instr), .npc(npc), .base_val(base_val), .nzp(nzp),
    .state(state), .br_taken(br_taken), .taddr(taddr), .ir(ir),
    .illegal(illegal), .timeout(timeout), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  // Monitor: every UPDATE_PC cycle is a retirement event checked against the queue
  always @(negedge clk) begin
    if (!rst && state == S_UPD_PC) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL upd_pc_unexpected: got retire event at retired=0x%04h expected none", retired);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("mon_ir",       ir,                e.ir);
        chk("mon_br_taken", {15'd0, br_taken}, {15'd0, e.br});
        chk("mon_taddr",    taddr,             e.taddr);
        chk("mon_retired",  retired,           e.retired);
        chk("mon_illegal",  {15'd0, illegal},  {15'd0, e.illegal});
        chk("mon_timeout",  {15'd0, timeout},  {15'd0, e.timeout});
      end
    end
  end

  task automatic push(input logic b, input logic [15:0] t, input logic [15:0] r,
                      input logic il, input logic to, input logic [15:0] iw);
    exp_t e;
    e = '{br: b, taddr: t, retired: r, illegal: il, timeout: to, ir: iw};
    exp_q.push_back(e);
  endtask

  task automatic expect_st(input logic [3:0] s, input string name);
    @(negedge clk);
    chk(name, {12'd0, state}, {12'd0, s});
  endtask

  // Called with FETCH just observed; leaves the DUT observed in EXECUTE.
  task automatic fetch_instr(input logic [15:0] iw);
    instr    = iw;
    imem_ack = 1'b1;
    expect_st(S_DECODE, "st_decode");
    imem_ack = 1'b0;
    expect_st(S_EXECUTE, "st_execute");
  endtask

  // n cycles in a memory wait state, ack raised for the last one.
  task automatic wait_mem(input logic [3:0] s, input int n, input string name);
    for (int i = 1; i <= n; i++) begin
      expect_st(s, name);
      dmem_ack = (i == n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
    instr = 16'h0; npc = 16'h0; base_val = 16'h0; nzp = 3'b000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state",    {12'd0, state},    {12'd0, S_FETCH});
    chk("rst_br_taken", {15'd0, br_taken}, 16'h0);
    chk("rst_taddr",    taddr,             16'h0);
    chk("rst_ir",       ir,                16'h0);
    chk("rst_illegal",  {15'd0, illegal},  16'h0);
    chk("rst_timeout",  {15'd0, timeout},  16'h0);
    chk("rst_retired",  retired,           16'h0);
    rst = 1'b0;

    // ADD
    push(1'b0, 16'h0000, 16'd0, 1'b0, 1'b0, 16'h1261);
    fetch_instr(16'h1261);
    expect_st(S_UPD_RF, "add_updrf");
    expect_st(S_UPD_PC, "add_updpc");
    expect_st(S_FETCH,  "add_fetch");
    chk("add_retired", retired, 16'd1);

    // BRnp +5 with Z set: not taken
    nzp = 3'b010; npc = 16'h3001;
    push(1'b0, 16'h3006, 16'd1, 1'b0, 1'b0, 16'h0A05);
    fetch_instr(16'h0A05);
    expect_st(S_CMP_PC, "brnp_cpc");
    chk("brnp_z_br", {15'd0, br_taken}, 16'h0);
    expect_st(S_UPD_PC, "brnp_updpc");
    expect_st(S_FETCH,  "brnp_fetch");

    // BRnp +5 with N set: taken
    nzp = 3'b100;
    push(1'b1, 16'h3006, 16'd2, 1'b0, 1'b0, 16'h0A05);
    fetch_instr(16'h0A05);
    expect_st(S_CMP_PC, "brn_cpc");
    chk("brnp_n_br", {15'd0, br_taken}, 16'h1);
    expect_st(S_UPD_PC, "brn_updpc");
    expect_st(S_FETCH,  "brn_fetch");
    chk("br_clear_at_fetch", {15'd0, br_taken}, 16'h0);

    // BRnzp -1 from npc 0 wraps
    nzp = 3'b010; npc = 16'h0000;
    push(1'b1, 16'hFFFF, 16'd3, 1'b0, 1'b0, 16'h0FFF);
    fetch_instr(16'h0FFF);
    expect_st(S_CMP_PC, "brnzp_cpc");
    expect_st(S_UPD_PC, "brnzp_updpc");
    expect_st(S_FETCH,  "brnzp_fetch");

    // JMP R7 ignores condition codes
    nzp = 3'b000; base_val = 16'h4000;
    push(1'b1, 16'h4000, 16'd4, 1'b0, 1'b0, 16'hC1C0);
    fetch_instr(16'hC1C0);
    expect_st(S_CMP_PC, "jmp_cpc");
    expect_st(S_UPD_PC, "jmp_updpc");
    expect_st(S_FETCH,  "jmp_fetch");

    // BR with empty nzp mask is never taken
    nzp = 3'b111; npc = 16'h1000;
    push(1'b0, 16'h1005, 16'd5, 1'b0, 1'b0, 16'h0005);
    fetch_instr(16'h0005);
    expect_st(S_CMP_PC, "br000_cpc");
    expect_st(S_UPD_PC, "br000_updpc");
    expect_st(S_FETCH,  "br000_fetch");

    // LDI with 3-cycle waits; the ack left high in UPDATE_REGF is ignored
    push(1'b0, 16'h1005, 16'd6, 1'b0, 1'b0, 16'hA402);
    fetch_instr(16'hA402);
    expect_st(S_CMP_MEM, "ldi_cmem");
    wait_mem(S_IND,  3, "ldi_ind");
    wait_mem(S_READ, 3, "ldi_read");
    expect_st(S_UPD_RF, "ldi_updrf");
    dmem_ack = 1'b0;
    expect_st(S_UPD_PC, "ldi_updpc");
    expect_st(S_FETCH,  "ldi_fetch");

    // ST with no ack: 16 wait cycles then watchdog abort
    push(1'b0, 16'h1005, 16'd7, 1'b0, 1'b1, 16'h3000);
    fetch_instr(16'h3000);
    expect_st(S_CMP_MEM, "st_cmem");
    for (int i = 0; i < 16; i++) expect_st(S_WRITE, "st_write_hold");
    expect_st(S_UPD_PC, "st_timeout_updpc");
    expect_st(S_FETCH,  "st_fetch");
    chk("timeout_pulse_end", {15'd0, timeout}, 16'h0);

    // STR with ack on the limit cycle: normal completion
    push(1'b0, 16'h1005, 16'd8, 1'b0, 1'b0, 16'h7000);
    fetch_instr(16'h7000);
    expect_st(S_CMP_MEM, "str_cmem");
    wait_mem(S_WRITE, 16, "str_write");
    expect_st(S_UPD_PC, "str_updpc");
    dmem_ack = 1'b0;
    expect_st(S_FETCH, "str_fetch");

    // Illegal opcode, then an AND: illegal stays set
    push(1'b0, 16'h1005, 16'd9, 1'b1, 1'b0, 16'hD000);
    fetch_instr(16'hD000);
    expect_st(S_UPD_PC, "ill_updpc");
    expect_st(S_FETCH,  "ill_fetch");
    chk("ill_sticky_1", {15'd0, illegal}, 16'h1);
    push(1'b0, 16'h1005, 16'd10, 1'b1, 1'b0, 16'h5020);
    fetch_instr(16'h5020);
    expect_st(S_UPD_RF, "and_updrf");
    expect_st(S_UPD_PC, "and_updpc");
    expect_st(S_FETCH,  "and_fetch");
    chk("ill_sticky_2", {15'd0, illegal}, 16'h1);

    // LD interrupted by reset in READ_MEM
    fetch_instr(16'h2000);
    expect_st(S_CMP_MEM, "ld_cmem");
    expect_st(S_READ, "ld_read1");
    expect_st(S_READ, "ld_read2");
    rst = 1'b1;
    expect_st(S_FETCH, "rst_mid_state");
    chk("rst_mid_retired", retired,           16'h0);
    chk("rst_mid_illegal", {15'd0, illegal},  16'h0);
    chk("rst_mid_taddr",   taddr,             16'h0);
    chk("rst_mid_ir",      ir,                16'h0);
    rst = 1'b0;

    push(1'b0, 16'h0000, 16'd0, 1'b0, 1'b0, 16'h1261);
    fetch_instr(16'h1261);
    expect_st(S_UPD_RF, "post_updrf");
    expect_st(S_UPD_PC, "post_updpc");
    expect_st(S_FETCH,  "post_fetch");
    chk("post_retired", retired, 16'd1);

    chk("sb_drained", 16'(exp_q.size()), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
